// File: rtl/led_uart_tx.sv
// led_uart_tx: queues every change of the 32-bit led word and prints it
// on a UART 8N1 line as 8 uppercase hex characters followed by CR LF.
// Ports: clk, rst (async, active-low), led[31:0] in;
//        tx (idle high), busy, fifo_level[FIFO_AW:0], dropped[15:0] out.
module led_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        led,
   output logic               tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [15:0]        dropped
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]    BAUD_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state_q, state_d;
   logic [31:0]         last_led_q, last_led_d;
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]    level_q, level_d;
   logic [15:0]         dropped_q, dropped_d;
   logic [CW-1:0]       baud_q, baud_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [3:0]          char_idx_q, char_idx_d;
   logic [31:0]         word_q, word_d;
   logic                tx_q, tx_d;

   logic [31:0]         mem [DEPTH];
   logic [31:0]         rd_data;
   logic                push, push_ok, drop, pop;
   logic                full, empty, strobe;
   logic [3:0]          nib;
   logic [7:0]          cur_char;

   assign rd_data = mem[rd_ptr_q];
   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign strobe  = (baud_q == BAUD_MAX);

   // Character currently on the wire: hex nibble, CR or LF.
   always_comb begin
      nib      = word_q[{3'd7 - char_idx_q[2:0], 2'b00} +: 4];
      cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                               : (8'h37 + {4'h0, nib});
      if (char_idx_q == 4'd8) cur_char = 8'h0D;
      if (char_idx_q == 4'd9) cur_char = 8'h0A;
   end

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      char_idx_d = char_idx_q;
      word_d     = word_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               word_d     = rd_data;
               char_idx_d = '0;
               state_d    = START;
               tx_d       = 1'b0;
            end
         end
         START: begin
            baud_d = strobe ? '0 : baud_q + CW'(1);
            if (strobe) begin
               state_d   = DATA;
               bit_idx_d = '0;
               tx_d      = cur_char[0];
            end
         end
         DATA: begin
            baud_d = strobe ? '0 : baud_q + CW'(1);
            if (strobe) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = cur_char[bit_idx_q + 3'd1];
               end
            end
         end
         STOP: begin
            baud_d = strobe ? '0 : baud_q + CW'(1);
            if (strobe) begin
               if (char_idx_q < 4'd9) begin
                  char_idx_d = char_idx_q + 4'd1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else if (!empty) begin
                  // Chain the next word with no idle gap.
                  pop        = 1'b1;
                  word_d     = rd_data;
                  char_idx_d = '0;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Change detect and FIFO bookkeeping. A simultaneous pop frees a
   // slot, so a push into a full FIFO is still accepted then.
   always_comb begin
      push       = (led != last_led_q);
      last_led_d = led;
      push_ok    = push && (!full || pop);
      drop       = push && full && !pop;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      dropped_d  = dropped_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop) level_d = level_q + 1'b1;
      if (!push_ok && pop) level_d = level_q - 1'b1;
      if (drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= led;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_led_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         dropped_q  <= '0;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         char_idx_q <= '0;
         word_q     <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_led_q <= last_led_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         dropped_q  <= dropped_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         char_idx_q <= char_idx_d;
         word_q     <= word_d;
         tx_q       <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign fifo_level = level_q;
   assign dropped    = dropped_q;

endmodule

// File: tb/tb_led_uart_tx.sv
// tb_led_uart_tx: scoreboard bench for led_uart_tx with CLKS_PER_BIT=4,
// FIFO_AW=3; a UART monitor decodes tx and compares against queued bytes.
module tb_led_uart_tx;

   localparam int CPB = 4;
   localparam int AW  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   led = '0;
   logic          tx;
   logic          busy;
   logic [AW:0]   fifo_level;
   logic [15:0]   dropped;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    exp_q[$];
   bit            mon_en = 1'b1;

   led_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk(clk), .rst(rst), .led(led), .tx(tx), .busy(busy),
      .fifo_level(fifo_level), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push_word(input logic [31:0] w);
      string hx;
      hx = "0123456789ABCDEF";
      for (int i = 0; i < 8; i++) begin
         logic [3:0] n;
         n = w[28 - 4*i +: 4];
         exp_q.push_back(8'(hx[int'(n)]));
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   task automatic count_busy(input int max, output int n, output bit to);
      n  = 0;
      to = 1'b1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (busy) n++;
         else begin
            to = 1'b0;
            break;
         end
      end
   endtask

   // UART monitor: samples mid-bit; a reset aborts the current frame.
   initial begin
      logic [9:0] bits;
      bit ok;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst && mon_en && tx == 1'b0) begin
            ok = 1'b1;
            bits = '0;
            bits[0] = tx;
            for (int c = 1; c <= CPB/2 + 9*CPB; c++) begin
               @(negedge clk);
               if (!rst) begin
                  ok = 1'b0;
                  break;
               end
               if (c >= CPB/2 && (c - CPB/2) % CPB == 0)
                  bits[(c - CPB/2) / CPB] = tx;
            end
            if (ok) begin
               checks++;
               if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                  errors++;
                  $display("FAIL framing: start=%b stop=%b want 0/1",
                           bits[0], bits[9]);
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rx_byte: got %h, none expected",
                           bits[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  if (bits[8:1] !== e) begin
                     errors++;
                     $display("FAIL rx_byte: got %h want %h", bits[8:1], e);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      int bad;
      rst = 1'b0;
      led = '0;
      repeat (3) tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== '0 ||
          dropped !== '0) begin
         errors++;
         $display("FAIL reset_state: tx=%b busy=%b lvl=%0d drop=%0d",
                  tx, busy, fifo_level, dropped);
      end
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== '0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL idle_zero: %0d bad cycles, want 0", bad);
      end
   endtask

   task automatic test_single();
      int n;
      bit to;
      led = 32'h1234ABCD;
      push_word(led);
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 4'd1) begin
         errors++;
         $display("FAIL single_e0: tx=%b busy=%b lvl=%0d want 1/0/1",
                  tx, busy, fifo_level);
      end
      tick();
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1 || fifo_level !== 4'd0) begin
         errors++;
         $display("FAIL single_e1: tx=%b busy=%b lvl=%0d want 0/1/0",
                  tx, busy, fifo_level);
      end
      count_busy(1000, n, to);
      checks++;
      if (to || n + 1 != 400) begin
         errors++;
         $display("FAIL single_len: busy %0d cycles (to=%0d) want 400",
                  n + 1, to);
      end
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_drain: %0d bytes left want 0", exp_q.size());
      end
   endtask

   task automatic test_burst();
      int n;
      bit to;
      for (int v = 1; v <= 20; v++) begin
         led = 32'(v);
         if (v <= 9) push_word(led);
         tick();
      end
      checks++;
      if (fifo_level !== 4'd8 || dropped !== 16'd11) begin
         errors++;
         $display("FAIL burst_lvl: lvl=%0d drop=%0d want 8/11",
                  fifo_level, dropped);
      end
      count_busy(5000, n, to);
      checks++;
      if (to || n + 19 != 3600) begin
         errors++;
         $display("FAIL burst_len: busy %0d cycles (to=%0d) want 3600",
                  n + 19, to);
      end
      tick();
      checks++;
      if (fifo_level !== '0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL burst_drain: lvl=%0d left=%0d want 0/0",
                  fifo_level, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit to;
      led = 32'hDEADBEEF;
      push_word(led);
      tick();
      repeat (98) tick();
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: tx=%b busy=%b want 0/1", tx, busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== '0 ||
          dropped !== '0) begin
         errors++;
         $display("FAIL mid_async: tx=%b busy=%b lvl=%0d drop=%0d",
                  tx, busy, fifo_level, dropped);
      end
      repeat (10) tick();
      exp_q.delete();
      push_word(led);
      rst = 1'b1;
      tick();
      count_busy(1000, n, to);
      checks++;
      if (to || n != 400) begin
         errors++;
         $display("FAIL mid_resend: busy %0d cycles (to=%0d) want 400",
                  n, to);
      end
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_drain: %0d bytes left want 0", exp_q.size());
      end
   endtask

   task automatic test_aba();
      int n;
      bit to;
      logic [31:0] seq [3];
      seq[0] = 32'h0000000A;
      seq[1] = 32'h0000000B;
      seq[2] = 32'h0000000A;
      for (int i = 0; i < 3; i++) begin
         led = seq[i];
         push_word(led);
         tick();
      end
      count_busy(2000, n, to);
      checks++;
      if (to || n + 2 != 1200) begin
         errors++;
         $display("FAIL aba_len: busy %0d cycles (to=%0d) want 1200",
                  n + 2, to);
      end
      tick();
      checks++;
      if (dropped !== '0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL aba_drain: drop=%0d left=%0d want 0/0",
                  dropped, exp_q.size());
      end
   endtask

   task automatic test_saturate();
      mon_en = 1'b0;
      for (int i = 0; i < 66000; i++) begin
         led = (i % 2 == 1) ? 32'h55 : 32'hAA;
         tick();
         if (i == 19) begin
            checks++;
            if (dropped !== 16'd11) begin
               errors++;
               $display("FAIL sat_early: drop=%0d want 11", dropped);
            end
         end
      end
      checks++;
      if (dropped !== 16'hFFFF || fifo_level !== 4'd8) begin
         errors++;
         $display("FAIL sat_reach: drop=%h lvl=%0d want ffff/8",
                  dropped, fifo_level);
      end
      led = 32'h12345678;
      tick();
      checks++;
      if (dropped !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold: drop=%h want ffff", dropped);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_reset_mid();
      test_aba();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
